// File: rtl/ldpc_ctrl_pkg.sv
// ldpc_ctrl_pkg
// Shared definitions for the LDPC iteration sequencer: the 4-bit binary
// state encoding and the default CN/VN phase lengths.
package ldpc_ctrl_pkg;

    // Default number of cycles each datapath phase stays enabled.
    localparam int DEF_CN_CYCLES = 16;
    localparam int DEF_VN_CYCLES = 16;

    // State encoding, 4-bit binary.
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_LOAD  = 4'd1;
    localparam logic [3:0] ST_CN    = 4'd2;
    localparam logic [3:0] ST_VN    = 4'd3;
    localparam logic [3:0] ST_SREQ  = 4'd4;
    localparam logic [3:0] ST_SWAIT = 4'd5;
    localparam logic [3:0] ST_INC   = 4'd6;
    localparam logic [3:0] ST_CHECK = 4'd7;
    localparam logic [3:0] ST_FIN   = 4'd8;

    typedef enum logic [3:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        CN    = ST_CN,
        VN    = ST_VN,
        SREQ  = ST_SREQ,
        SWAIT = ST_SWAIT,
        INC   = ST_INC,
        CHECK = ST_CHECK,
        FIN   = ST_FIN
    } ctrl_state_t;

endpackage

// File: rtl/ldpc_phase_timer.sv
// ldpc_phase_timer
// Loadable down-counter timing the CN and VN phases. Loaded with
// (phase length - 1) on the cycle before a phase starts, then counts down
// and parks at zero.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   load     load load_val at the next clock edge
//   load_val value loaded into the counter
//   zero     counter is zero (last cycle of the current phase)
module ldpc_phase_timer #(
    parameter int PHASE_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [PHASE_BITS-1:0] load_val,
    output logic                  zero
);

    logic [PHASE_BITS-1:0] cnt;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl
// Iteration sequencer for the LDPC decoder. Each iteration runs the CN
// phase, the VN phase and a syndrome check; the decode ends on an all-zero
// syndrome (success), on reaching the iteration limit (fail) or on abort.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a decode (accepted in IDLE only)
//   max_iter        iteration limit, sampled with start (0 treated as 1)
//   abort           end the current decode with a fail result
//   syndrome_zero   syndrome result, qualified by syn_valid
//   syn_valid       syndrome result valid
//   it_count        external iteration counter value
//   it_cnt_rst      iteration counter reset
//   it_cnt_en       iteration counter increment
//   it_stop_val     iteration counter stop value (latched limit)
//   cn_en, vn_en    CN / VN phase enables
//   syn_req         one-cycle syndrome evaluation request
//   busy            high in every state except IDLE
//   done            one-cycle end-of-decode pulse
//   success         decode result, held until the next accepted start
//   iters_used      iterations executed, held until the next accepted start
module ldpc_iter_ctrl
    import ldpc_ctrl_pkg::*;
#(
    parameter int COUNT_MAX_BITS = 10,
    parameter int CN_CYCLES      = DEF_CN_CYCLES,
    parameter int VN_CYCLES      = DEF_VN_CYCLES,
    parameter int PHASE_BITS     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [COUNT_MAX_BITS-1:0] max_iter,
    input  logic                      abort,
    input  logic                      syndrome_zero,
    input  logic                      syn_valid,
    input  logic [COUNT_MAX_BITS-1:0] it_count,
    output logic                      it_cnt_rst,
    output logic                      it_cnt_en,
    output logic [COUNT_MAX_BITS-1:0] it_stop_val,
    output logic                      cn_en,
    output logic                      vn_en,
    output logic                      syn_req,
    output logic                      busy,
    output logic                      done,
    output logic                      success,
    output logic [COUNT_MAX_BITS-1:0] iters_used
);

    localparam logic [PHASE_BITS-1:0] CN_LOAD = PHASE_BITS'(CN_CYCLES - 1);
    localparam logic [PHASE_BITS-1:0] VN_LOAD = PHASE_BITS'(VN_CYCLES - 1);

    ctrl_state_t state, next_state;

    logic                      timer_load;
    logic [PHASE_BITS-1:0]     timer_val;
    logic                      timer_zero;
    logic                      take_start;
    logic                      end_now;
    logic                      end_success;
    logic [COUNT_MAX_BITS-1:0] end_iters;
    logic                      abortable;

    ldpc_phase_timer #(
        .PHASE_BITS(PHASE_BITS)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    assign abortable = (state != IDLE) && (state != FIN);

    // NOTE: reset is synchronous; it is just another term of the clocked
    // process and only takes effect on a clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        next_state  = state;
        take_start  = 1'b0;
        end_now     = 1'b0;
        end_success = 1'b0;
        end_iters   = it_count;
        timer_load  = 1'b0;
        timer_val   = CN_LOAD;

        case (state)
            IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD:  next_state = CN;
            CN:    if (timer_zero) next_state = VN;
            VN:    if (timer_zero) next_state = SREQ;
            // A syn_valid coinciding with the request belongs to no request.
            SREQ:  next_state = SWAIT;
            SWAIT: begin
                if (syn_valid) begin
                    if (syndrome_zero) begin
                        end_now     = 1'b1;
                        end_success = 1'b1;
                        // Counter has not yet counted the current iteration.
                        end_iters   = it_count + COUNT_MAX_BITS'(1);
                        next_state  = FIN;
                    end else begin
                        next_state = INC;
                    end
                end
            end
            INC:   next_state = CHECK;
            CHECK: begin
                if (it_count == it_stop_val) begin
                    end_now    = 1'b1;
                    next_state = FIN;
                end else begin
                    next_state = CN;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Abort overrides whatever the state decided, including a syndrome result.
        if (abort && abortable) begin
            end_now     = 1'b1;
            end_success = 1'b0;
            end_iters   = it_count;
            next_state  = FIN;
        end

        // Load the timer on the cycle before a phase starts so its first cycle
        // already sees (length - 1).
        if (next_state == CN && state != CN) begin
            timer_load = 1'b1;
            timer_val  = CN_LOAD;
        end else if (next_state == VN && state != VN) begin
            timer_load = 1'b1;
            timer_val  = VN_LOAD;
        end
    end

    // Outputs are registered decodes of the next state, so each strobe is high
    // exactly while the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            it_cnt_rst  <= 1'b0;
            it_cnt_en   <= 1'b0;
            it_stop_val <= '0;
            cn_en       <= 1'b0;
            vn_en       <= 1'b0;
            syn_req     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            success     <= 1'b0;
            iters_used  <= '0;
        end else begin
            it_cnt_rst <= (next_state == LOAD);
            it_cnt_en  <= (next_state == INC);
            cn_en      <= (next_state == CN);
            vn_en      <= (next_state == VN);
            syn_req    <= (next_state == SREQ);
            busy       <= (next_state != IDLE);
            done       <= (next_state == FIN);
            if (take_start) begin
                it_stop_val <= (max_iter == '0) ? COUNT_MAX_BITS'(1) : max_iter;
                success     <= 1'b0;
                iters_used  <= '0;
            end else if (end_now) begin
                success    <= end_success;
                iters_used <= end_iters;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb_ldpc_iter_ctrl
// Scoreboard bench for ldpc_iter_ctrl with CN_CYCLES=VN_CYCLES=4. The bench
// models the external iteration counter and a syndrome unit that answers
// each syn_req a fixed number of cycles later.
module tb_ldpc_iter_ctrl;

    localparam int CMB = 10;
    localparam int NCN = 4;
    localparam int NVN = 4;
    localparam int BUDGET = 600;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [CMB-1:0] max_iter;
    logic           abort;
    logic           syndrome_zero;
    logic           syn_valid;
    logic [CMB-1:0] it_count;
    logic           it_cnt_rst;
    logic           it_cnt_en;
    logic [CMB-1:0] it_stop_val;
    logic           cn_en;
    logic           vn_en;
    logic           syn_req;
    logic           busy;
    logic           done;
    logic           success;
    logic [CMB-1:0] iters_used;

    always #5 clk = ~clk;

    ldpc_iter_ctrl #(
        .COUNT_MAX_BITS (CMB),
        .CN_CYCLES      (NCN),
        .VN_CYCLES      (NVN),
        .PHASE_BITS     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .max_iter      (max_iter),
        .abort         (abort),
        .syndrome_zero (syndrome_zero),
        .syn_valid     (syn_valid),
        .it_count      (it_count),
        .it_cnt_rst    (it_cnt_rst),
        .it_cnt_en     (it_cnt_en),
        .it_stop_val   (it_stop_val),
        .cn_en         (cn_en),
        .vn_en         (vn_en),
        .syn_req       (syn_req),
        .busy          (busy),
        .done          (done),
        .success       (success),
        .iters_used    (iters_used)
    );

    // External iteration counter, stops at it_stop_val.
    always_ff @(posedge clk) begin
        if (rst || it_cnt_rst) begin
            it_count <= '0;
        end else if (it_cnt_en && it_count != it_stop_val) begin
            it_count <= it_count + 1'b1;
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic           success;
        logic [CMB-1:0] iters;
        int             incs;
        int             cn_cyc;
        int             vn_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Syndrome responder configuration and drive.
    int   syn_delay   = 2;
    int   zero_iter   = 0;
    bit   resp_en     = 1'b1;
    bit   expect_cut  = 1'b0;
    logic resp_valid  = 1'b0;
    logic resp_zero   = 1'b0;
    logic stray_valid = 1'b0;

    assign syn_valid     = resp_valid | stray_valid;
    assign syndrome_zero = resp_zero | stray_valid;

    initial begin
        int pend    = 0;
        int req_idx = 0;
        forever begin
            @(negedge clk);
            resp_valid = 1'b0;
            resp_zero  = 1'b0;
            if (rst || it_cnt_rst) begin
                pend    = 0;
                req_idx = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        resp_valid = 1'b1;
                        resp_zero  = (req_idx == zero_iter);
                    end
                end
                if (resp_en && syn_req) begin
                    req_idx++;
                    pend = syn_delay;
                end
            end
        end
    end

    // Monitor: phase run lengths, exclusivity of strobes, scoreboard on done.
    initial begin
        int   cn_run = 0, vn_run = 0, cn_tot = 0, vn_tot = 0, inc_tot = 0;
        logic prev_cn = 1'b0, prev_vn = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst || it_cnt_rst) begin
                cn_run = 0; vn_run = 0; cn_tot = 0; vn_tot = 0; inc_tot = 0;
                prev_cn = 1'b0; prev_vn = 1'b0;
            end else begin
                checks++;
                if ($countones({cn_en, vn_en, syn_req, it_cnt_en}) > 1) begin
                    failures++;
                    $display("FAIL strobe_onehot: got cn/vn/req/inc=%b%b%b%b, want at most one high",
                             cn_en, vn_en, syn_req, it_cnt_en);
                end
                if (cn_en) begin
                    cn_run++; cn_tot++;
                end else if (prev_cn) begin
                    if (!expect_cut) begin
                        checks++;
                        if (cn_run != NCN) begin
                            failures++;
                            $display("FAIL cn_run_len: got %0d, want %0d", cn_run, NCN);
                        end
                    end
                    cn_run = 0;
                end
                if (vn_en) begin
                    vn_run++; vn_tot++;
                end else if (prev_vn) begin
                    if (!expect_cut) begin
                        checks++;
                        if (vn_run != NVN) begin
                            failures++;
                            $display("FAIL vn_run_len: got %0d, want %0d", vn_run, NVN);
                        end
                    end
                    vn_run = 0;
                end
                if (it_cnt_en) inc_tot++;
                prev_cn = cn_en;
                prev_vn = vn_en;
                if (done) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_done: got done=1 with success=%0b iters_used=%0d, want no done",
                                 success, iters_used);
                    end else begin
                        e = exp_q.pop_front();
                        if (success !== e.success || iters_used !== e.iters) begin
                            failures++;
                            $display("FAIL result: got success=%0b iters_used=%0d, want success=%0b iters_used=%0d",
                                     success, iters_used, e.success, e.iters);
                        end
                        checks++;
                        if (inc_tot != e.incs || cn_tot != e.cn_cyc || vn_tot != e.vn_cyc) begin
                            failures++;
                            $display("FAIL activity: got inc=%0d cn=%0d vn=%0d, want inc=%0d cn=%0d vn=%0d",
                                     inc_tot, cn_tot, vn_tot, e.incs, e.cn_cyc, e.vn_cyc);
                        end
                    end
                end
            end
        end
    end

    // Expected result of a decode that is not aborted.
    task automatic push_decode(input int mi, input int zi);
        exp_t e;
        int   mx;
        mx = (mi == 0) ? 1 : mi;
        if (zi >= 1 && zi <= mx) begin
            e.success = 1'b1;
            e.iters   = CMB'(zi);
            e.incs    = zi - 1;
            e.cn_cyc  = NCN * zi;
            e.vn_cyc  = NVN * zi;
        end else begin
            e.success = 1'b0;
            e.iters   = CMB'(mx);
            e.incs    = mx;
            e.cn_cyc  = NCN * mx;
            e.vn_cyc  = NVN * mx;
        end
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int mi);
        @(negedge clk);
        max_iter = CMB'(mi);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Waits for done; leaves time #1 past the negedge so the monitor has run.
    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done in %0d cycles, want done", tag, BUDGET);
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; max_iter = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cn_en, vn_en, syn_req, it_cnt_en, it_cnt_rst} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b, want 00000", {cn_en, vn_en, syn_req, it_cnt_en, it_cnt_rst});
        end
        checks++;
        if ({busy, done, success} !== 3'b0) begin
            failures++;
            $display("FAIL reset_status: got busy/done/success=%b, want 000", {busy, done, success});
        end
        checks++;
        if (it_stop_val !== '0 || iters_used !== '0) begin
            failures++;
            $display("FAIL reset_values: got stop=%0d iters=%0d, want 0 0", it_stop_val, iters_used);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fail_max;
        zero_iter = 0;
        push_decode(3, 0);
        pulse_start(3);
        checks++;
        if (it_stop_val !== CMB'(3) || busy !== 1'b1) begin
            failures++;
            $display("FAIL fail_stop_val: got stop=%0d busy=%0b, want 3 1", it_stop_val, busy);
        end
        wait_done("fail_max");
        repeat (3) @(negedge clk);
        checks++;
        if (success !== 1'b0 || iters_used !== CMB'(3) || busy !== 1'b0) begin
            failures++;
            $display("FAIL fail_held: got success=%0b iters=%0d busy=%0b, want 0 3 0", success, iters_used, busy);
        end
    endtask

    task automatic test_success;
        zero_iter = 2;
        push_decode(5, 2);
        pulse_start(5);
        checks++;
        if (success !== 1'b0 || iters_used !== '0) begin
            failures++;
            $display("FAIL success_cleared: got success=%0b iters=%0d, want 0 0", success, iters_used);
        end
        wait_done("success");
        @(negedge clk);
        checks++;
        if (success !== 1'b1 || iters_used !== CMB'(2)) begin
            failures++;
            $display("FAIL success_held: got success=%0b iters=%0d, want 1 2", success, iters_used);
        end
        zero_iter = 0;
    endtask

    task automatic test_max_zero;
        push_decode(0, 0);
        pulse_start(0);
        checks++;
        if (it_stop_val !== CMB'(1)) begin
            failures++;
            $display("FAIL max_zero_clamp: got stop=%0d, want 1", it_stop_val);
        end
        wait_done("max_zero");
        @(negedge clk);
    endtask

    task automatic test_abort;
        exp_t e;
        bit   hit = 1'b0;
        e.success = 1'b0; e.iters = CMB'(1); e.incs = 1; e.cn_cyc = 2 * NCN; e.vn_cyc = NVN + 1;
        exp_q.push_back(e);
        expect_cut = 1'b1;
        pulse_start(4);
        for (int i = 0; i < BUDGET && !hit; i++) begin
            @(negedge clk);
            if (vn_en && it_count == CMB'(1)) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL abort_reach_vn2: got no second VN phase, want one");
        end
        abort = 1'b1; stray_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; stray_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || success !== 1'b0 || iters_used !== CMB'(1)) begin
            failures++;
            $display("FAIL abort_fin: got done=%0b success=%0b iters=%0d, want 1 0 1", done, success, iters_used);
        end
        #1;
        @(negedge clk);
        expect_cut = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%0b done=%0b, want 0 0", busy, done);
        end
    endtask

    task automatic test_rst_in_swait;
        bit hit = 1'b0;
        int dones = 0;
        resp_en = 1'b0;
        pulse_start(3);
        for (int i = 0; i < BUDGET && !hit; i++) begin
            @(negedge clk);
            if (syn_req) hit = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, cn_en, vn_en, syn_req, it_cnt_en, it_cnt_rst, success} !== 8'b0 ||
            it_stop_val !== '0 || iters_used !== '0 || !hit) begin
            failures++;
            $display("FAIL rst_outputs: got flags=%b stop=%0d iters=%0d reached=%0b, want 0 0 0 1",
                     {busy, done, cn_en, vn_en, syn_req, it_cnt_en, it_cnt_rst, success},
                     it_stop_val, iters_used, hit);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL rst_no_done: got %0d done pulses, want 0", dones);
        end
        resp_en = 1'b1;
        push_decode(2, 0);
        pulse_start(2);
        @(negedge clk);
        checks++;
        if (cn_en !== 1'b1 || it_count !== '0) begin
            failures++;
            $display("FAIL rst_restart_count: got cn_en=%0b count=%0d, want 1 0", cn_en, it_count);
        end
        wait_done("rst_restart");
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        push_decode(1, 0);
        push_decode(1, 0);
        @(negedge clk);
        max_iter = CMB'(1);
        start    = 1'b1;
        wait_done("b2b_first");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got busy=%0b done=%0b, want 0 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || it_cnt_rst !== 1'b1 || success !== 1'b0 || iters_used !== '0) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%0b cnt_rst=%0b success=%0b iters=%0d, want 1 1 0 0",
                     busy, it_cnt_rst, success, iters_used);
        end
        start = 1'b0;
        wait_done("b2b_second");
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fail_max();
        test_success();
        test_max_zero();
        test_abort();
        test_rst_in_swait();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending results, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, want completion");
        $fatal(1, "global timeout");
    end

endmodule
